// File: rtl/cu_responder.sv
// Channel control-unit responder: address recognition, command, status and byte transfer sequencing.
// Optional CU_SHORT_BUSY_EN: report busy with an immediate short status instead of the full sequence.
module cu_responder #(
  parameter logic [7:0] ADDRESS = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_out,
  output logic [7:0] bus_in,
  input  logic       operational_out,
  input  logic       hold_out,
  input  logic       address_out,
  input  logic       command_out,
  input  logic       service_out,
  input  logic       suppress_out,
  input  logic       select_out,
  output logic       select_in,
  output logic       b_select_out,
  input  logic       b_select_in,
  output logic       operational_in,
  output logic       address_in,
  output logic       status_in,
  output logic       service_in,
  output logic       request_in,
  input  logic       busy,
  input  logic [7:0] xfer_count,
  input  logic [7:0] rd_data,
  output logic       rd_strobe,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  output logic [7:0] cmd,
  output logic       cmd_strobe
);

`ifdef CU_SHORT_BUSY_EN
  localparam bit SHORT_BUSY = 1'b1;
`else
  localparam bit SHORT_BUSY = 1'b0;
`endif

  typedef enum logic [3:0] {IDLE, ADDR, CMD, ISTAT, DATA, DWAIT, ESTAT, SWAIT, DISC} state_t;

  state_t     state_q, state_d;
  logic [7:0] bus_in_q, bus_in_d, cmd_q, cmd_d, wr_data_q, wr_data_d;
  logic [7:0] status_q, status_d, rem_q, rem_d;
  logic       op_in_q, op_in_d, addr_in_q, addr_in_d, stat_in_q, stat_in_d, svc_in_q, svc_in_d;
  logic       rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d, cmd_stb_q, cmd_stb_d;
  logic       busy_q, busy_d, stop_q, stop_d, ack_q, ack_d, bsel_q;
  logic       match, is_read, is_write, go_data, go_estat, go_disc;
  logic       unused_inputs;

  assign unused_inputs = suppress_out;

  assign match    = (state_q == IDLE) && operational_out && select_out && hold_out &&
                    address_out && (bus_out == ADDRESS);
  assign is_read  = (cmd_q == 8'h02);
  assign is_write = (cmd_q == 8'h01);

  // Select chain is only propagated while idle and not being claimed this cycle.
  assign b_select_out   = bsel_q && (state_q == IDLE) && !match;
  assign select_in      = (state_q == IDLE) && b_select_in;
  assign request_in     = 1'b0;
  assign bus_in         = bus_in_q;
  assign operational_in = op_in_q;
  assign address_in     = addr_in_q;
  assign status_in      = stat_in_q;
  assign service_in     = svc_in_q;
  assign rd_strobe      = rd_stb_q;
  assign wr_strobe      = wr_stb_q;
  assign wr_data        = wr_data_q;
  assign cmd            = cmd_q;
  assign cmd_strobe     = cmd_stb_q;

  always_comb begin
    state_d   = state_q;
    bus_in_d  = bus_in_q;
    op_in_d   = op_in_q;
    addr_in_d = addr_in_q;
    stat_in_d = stat_in_q;
    svc_in_d  = svc_in_q;
    rd_stb_d  = 1'b0;
    wr_stb_d  = 1'b0;
    cmd_stb_d = 1'b0;
    cmd_d     = cmd_q;
    wr_data_d = wr_data_q;
    status_d  = status_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    stop_d    = stop_q;
    ack_d     = ack_q;
    go_data   = 1'b0;
    go_estat  = 1'b0;
    go_disc   = 1'b0;

    case (state_q)
      IDLE: if (match) begin
        busy_d  = busy;
        op_in_d = 1'b1;
        stop_d  = 1'b0;
        ack_d   = 1'b0;
        if (SHORT_BUSY && busy) begin
          state_d   = ISTAT;
          stat_in_d = 1'b1;
          bus_in_d  = 8'h10;
          status_d  = 8'h10;
        end else begin
          state_d   = ADDR;
          addr_in_d = 1'b1;
          bus_in_d  = ADDRESS;
        end
      end
      ADDR: if (command_out) begin
        state_d   = CMD;
        addr_in_d = 1'b0;
        cmd_d     = bus_out;
        cmd_stb_d = 1'b1;
        rem_d     = xfer_count;
        if (busy_q)                                   status_d = 8'h10;
        else if (bus_out == 8'h01 || bus_out == 8'h02) status_d = 8'h00;
        else if (bus_out == 8'h03)                    status_d = 8'h0C;
        else                                          status_d = 8'h02;
      end
      CMD: if (!command_out) begin
        state_d   = ISTAT;
        stat_in_d = 1'b1;
        bus_in_d  = status_q;
        ack_d     = 1'b0;
      end
      ISTAT: begin
        if (!ack_q) begin
          if (command_out) go_disc = 1'b1;
          else if (service_out) begin
            stat_in_d = 1'b0;
            ack_d     = 1'b1;
          end
        end else if (!service_out) begin
          if (status_q != 8'h00) go_disc  = 1'b1;
          else if (rem_q != '0)  go_data  = 1'b1;
          else                   go_estat = 1'b1;
        end
      end
      // Reads spend one cycle strobing the device before the byte is offered on bus_in.
      DATA: begin
        if (rd_stb_q) begin
          bus_in_d = rd_data;
          svc_in_d = 1'b1;
        end else if (svc_in_q) begin
          if (command_out) begin
            stop_d   = 1'b1;
            svc_in_d = 1'b0;
            state_d  = DWAIT;
          end else if (service_out) begin
            if (is_write) begin
              wr_data_d = bus_out;
              wr_stb_d  = 1'b1;
            end
            if (rem_q != '0) rem_d = rem_q - 8'd1;
            svc_in_d = 1'b0;
            state_d  = DWAIT;
          end
        end
      end
      DWAIT: if (!service_out && !command_out) begin
        if (rem_q != '0 && !stop_q) go_data  = 1'b1;
        else                        go_estat = 1'b1;
      end
      ESTAT: if (service_out || command_out) begin
        stat_in_d = 1'b0;
        state_d   = SWAIT;
      end
      SWAIT: if (!service_out && !command_out) go_disc = 1'b1;
      DISC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_data) begin
      state_d = DATA;
      if (is_read) rd_stb_d = 1'b1;
      else         svc_in_d = 1'b1;
    end
    if (go_estat) begin
      state_d   = ESTAT;
      stat_in_d = 1'b1;
      bus_in_d  = 8'h0C;
    end
    if (go_disc || !operational_out) begin
      state_d   = go_disc ? DISC : IDLE;
      bus_in_d  = '0;
      op_in_d   = 1'b0;
      addr_in_d = 1'b0;
      stat_in_d = 1'b0;
      svc_in_d  = 1'b0;
    end
    if (!operational_out) begin
      rd_stb_d  = 1'b0;
      wr_stb_d  = 1'b0;
      cmd_stb_d = 1'b0;
      stop_d    = 1'b0;
      ack_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bus_in_q  <= '0;
      op_in_q   <= 1'b0;
      addr_in_q <= 1'b0;
      stat_in_q <= 1'b0;
      svc_in_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      cmd_stb_q <= 1'b0;
      cmd_q     <= '0;
      wr_data_q <= '0;
      status_q  <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      stop_q    <= 1'b0;
      ack_q     <= 1'b0;
      bsel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_in_q  <= bus_in_d;
      op_in_q   <= op_in_d;
      addr_in_q <= addr_in_d;
      stat_in_q <= stat_in_d;
      svc_in_q  <= svc_in_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      cmd_stb_q <= cmd_stb_d;
      cmd_q     <= cmd_d;
      wr_data_q <= wr_data_d;
      status_q  <= status_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      stop_q    <= stop_d;
      ack_q     <= ack_d;
      bsel_q    <= select_out;
    end
  end

endmodule

// File: tb/tb_cu_responder.sv
// Scoreboard bench for cu_responder: directed channel sequences, monitor checks every DUT event.
module tb_cu_responder;

  localparam int EV_ADDR = 0, EV_CMD = 1, EV_STAT = 2, EV_RD = 3, EV_WR = 4, EV_END = 5;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic       clk, reset;
  logic [7:0] bus_out, bus_in;
  logic       operational_out, hold_out, address_out, command_out, service_out, suppress_out;
  logic       select_out, select_in, b_select_out, b_select_in;
  logic       operational_in, address_in, status_in, service_in, request_in;
  logic       busy, rd_strobe, wr_strobe, cmd_strobe;
  logic [7:0] xfer_count, rd_data, wr_data, cmd;
  logic [7:0] rd_cnt;
  logic       p_addr, p_stat, p_svc, p_op;

  ev_t sb[$];
  int  n_vec, n_bad;

  cu_responder #(.ADDRESS(8'h1a)) dut (
    .clk(clk), .reset(reset), .bus_out(bus_out), .bus_in(bus_in),
    .operational_out(operational_out), .hold_out(hold_out), .address_out(address_out),
    .command_out(command_out), .service_out(service_out), .suppress_out(suppress_out),
    .select_out(select_out), .select_in(select_in), .b_select_out(b_select_out),
    .b_select_in(b_select_in), .operational_in(operational_in), .address_in(address_in),
    .status_in(status_in), .service_in(service_in), .request_in(request_in),
    .busy(busy), .xfer_count(xfer_count), .rd_data(rd_data), .rd_strobe(rd_strobe),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .cmd(cmd), .cmd_strobe(cmd_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device read source: next byte advances on every strobe.
  initial rd_cnt = 8'h00;
  always @(posedge clk) if (rd_strobe) rd_cnt <= rd_cnt + 8'd1;
  assign rd_data = 8'h50 + rd_cnt;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [7:0] val, input string nm);
    ev_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event value %0h, nothing expected", nm, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_bad++;
        $display("FAIL %s: got kind %0d value %0h, expected kind %0d value %0h",
                 nm, kind, val, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (address_in && !p_addr) check_ev(EV_ADDR, bus_in, "addr_echo");
      if (cmd_strobe) check_ev(EV_CMD, cmd, "cmd_accept");
      if (status_in && !p_stat) check_ev(EV_STAT, bus_in, "status_byte");
      if (service_out && !p_svc && service_in && cmd == 8'h02) check_ev(EV_RD, bus_in, "rd_byte");
      if (wr_strobe) check_ev(EV_WR, wr_data, "wr_byte");
      if (!operational_in && p_op) check_ev(EV_END, bus_in, "disconnect");
    end
    p_addr <= address_in;
    p_stat <= status_in;
    p_svc  <= service_out;
    p_op   <= operational_in;
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return address_in;
      1:       return status_in;
      2:       return service_in;
      default: return operational_in;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input string nm);
    for (int i = 0; i < 100; i++) begin
      if (sig(sel) == val) return;
      @(posedge clk); #1;
    end
    n_vec++;
    n_bad++;
    $display("FAIL timeout %s: signal %0d never reached %0b", nm, sel, val);
  endtask

  // abort_mode: 0 none, 1 drop operational_out at first byte, 2 reset at first byte
  task automatic xact(input logic [7:0] c, input int cnt, input int chan, input bit bsy,
                      input bit stack, input int abort_mode);
    logic [7:0] st, base, exp_rd;
    bit short_b, data, stop;
    int n_acc;
    base = rd_cnt;
    if (bsy)                          st = 8'h10;
    else if (c == 8'h01 || c == 8'h02) st = 8'h00;
    else if (c == 8'h03)              st = 8'h0C;
    else                              st = 8'h02;
    short_b = 1'b0;
`ifdef CU_SHORT_BUSY_EN
    short_b = bsy;
`endif
    data  = (st == 8'h00) && !stack && (cnt > 0);
    n_acc = data ? ((chan < cnt) ? chan : cnt) : 0;
    stop  = data && (chan < cnt);
    if (abort_mode != 0) begin
      n_acc = 0;
      stop  = 1'b0;
    end
    exp_rd = (c == 8'h02 && data) ? 8'(n_acc + ((stop || abort_mode != 0) ? 1 : 0)) : 8'h00;

    if (!short_b) begin
      push(EV_ADDR, 8'h1a);
      push(EV_CMD, c);
    end
    push(EV_STAT, st);
    for (int k = 0; k < n_acc; k++) begin
      if (c == 8'h02) push(EV_RD, 8'h50 + base + 8'(k));
      else            push(EV_WR, 8'hA0 + 8'(k));
    end
    if (st == 8'h00 && !stack && abort_mode == 0) push(EV_STAT, 8'h0C);
    if (abort_mode != 2) push(EV_END, 8'h00);

    busy = bsy; xfer_count = 8'(cnt); bus_out = 8'h1a;
    select_out = 1'b1; hold_out = 1'b1; address_out = 1'b1;
    if (short_b) wait_sig(1, 1'b1, "short_busy_status");
    else         wait_sig(0, 1'b1, "addr_recognise");
    check("bsel_forced_low", b_select_out, 0);
    address_out = 1'b0;
    if (!short_b) begin
      bus_out = c; command_out = 1'b1;
      wait_sig(0, 1'b0, "cmd_phase");
      command_out = 1'b0; bus_out = 8'h00;
      wait_sig(1, 1'b1, "init_status");
    end
    if (stack) command_out = 1'b1;
    else       service_out = 1'b1;
    wait_sig(1, 1'b0, "init_status_ack");
    command_out = 1'b0; service_out = 1'b0;

    if (data) begin
      for (int k = 0; k < n_acc; k++) begin
        wait_sig(2, 1'b1, "svc_in_rise");
        if (c == 8'h01) bus_out = 8'hA0 + 8'(k);
        service_out = 1'b1;
        wait_sig(2, 1'b0, "svc_in_drop");
        service_out = 1'b0;
      end
      if (stop) begin
        wait_sig(2, 1'b1, "svc_in_stop");
        command_out = 1'b1;
        wait_sig(2, 1'b0, "stop_drop");
        command_out = 1'b0;
      end
      if (abort_mode == 1) begin
        wait_sig(2, 1'b1, "svc_in_abort");
        operational_out = 1'b0;
        @(posedge clk); #1;
        check("opdrop_op_in", operational_in, 0);
        check("opdrop_svc_in", service_in, 0);
        check("opdrop_bus_in", bus_in, 0);
        operational_out = 1'b1;
      end
      if (abort_mode == 2) begin
        wait_sig(2, 1'b1, "svc_in_reset");
        reset = 1'b1;
        #2;
        check("async_rst_op_in", operational_in, 0);
        check("async_rst_svc_in", service_in, 0);
        @(posedge clk); #1;
        reset = 1'b0;
      end
    end
    if (st == 8'h00 && !stack && abort_mode == 0) begin
      wait_sig(1, 1'b1, "end_status");
      service_out = 1'b1;
      wait_sig(1, 1'b0, "end_status_ack");
      service_out = 1'b0;
    end
    wait_sig(3, 1'b0, "disconnect");
    select_out = 1'b0; hold_out = 1'b0; bus_out = 8'h00; busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rd_strobe_count", rd_cnt - base, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1'b1; bus_out = 8'h00; operational_out = 1'b0; hold_out = 1'b0;
    address_out = 1'b0; command_out = 1'b0; service_out = 1'b0; suppress_out = 1'b0;
    select_out = 1'b1; b_select_in = 1'b0; busy = 1'b0; xfer_count = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_in", bus_in, 0);
    check("rst_tag_ins", {operational_in, address_in, status_in, service_in, request_in}, 0);
    check("rst_b_select_out", b_select_out, 0);
    check("rst_strobes", {rd_strobe, wr_strobe, cmd_strobe}, 0);
    check("rst_cmd", cmd, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b0; select_out = 1'b0; operational_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Foreign address: pass select down the chain, stay silent.
    bus_out = 8'h10; select_out = 1'b1; hold_out = 1'b1; address_out = 1'b1; b_select_in = 1'b1;
    @(negedge clk);
    check("bsel_lag_cycle0", b_select_out, 0);
    check("select_in_pass", select_in, 1);
    @(negedge clk);
    check("bsel_follows", b_select_out, 1);
    repeat (3) @(negedge clk);
    check("foreign_no_tags", {operational_in, address_in, status_in, service_in}, 0);
    @(posedge clk); #1;
    select_out = 1'b0; hold_out = 1'b0; address_out = 1'b0; bus_out = 8'h00; b_select_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    xact(8'h02, 6,  16, 1'b0, 1'b0, 0);  // device count ends the read
    xact(8'h02, 16, 6,  1'b0, 1'b0, 0);  // channel stops the read
    xact(8'h01, 6,  16, 1'b0, 1'b0, 0);  // write A0..A5
    xact(8'h02, 4,  16, 1'b1, 1'b0, 0);  // busy
    xact(8'hff, 4,  16, 1'b0, 1'b0, 0);  // unit check
    xact(8'h03, 4,  16, 1'b0, 1'b0, 0);  // NOP
    xact(8'h01, 0,  16, 1'b0, 1'b0, 0);  // zero-length write
    xact(8'h02, 4,  16, 1'b0, 1'b1, 0);  // stacked initial status
    xact(8'h02, 4,  16, 1'b0, 1'b0, 1);  // operational_out dropped
    xact(8'h02, 2,  16, 1'b0, 1'b0, 0);
    xact(8'h02, 4,  16, 1'b0, 1'b0, 2);  // reset mid-transfer
    xact(8'h02, 1,  16, 1'b0, 1'b0, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
